uart_rx: RTL and testbench

- UART receiver: the receive-side counterpart of the core's uart_tx serial output.
- Line format is 8N1: 1 start bit, 8 data bits LSB first, no parity, 1 stop bit.
- Oversamples an asynchronous serial line, assembles bytes and buffers them in a small FIFO.
- Presents bytes to the core's MMIO/UART register block through a ready/valid interface, and flags framing and overrun errors.

---
 rtl/uart_pkg.sv | 16 +
 rtl/sync_fifo.sv | 71 +++++++
 rtl/uart_rx.sv | 140 ++++++++++++++
 tb/tb_uart_rx.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states, frame width and the default bit period.
// The transmitter uses the same constants, so both ends agree on the line rate.
package uart_pkg;

    localparam int UART_DATA_BITS    = 8;
    localparam int UART_CLKS_PER_BIT = 234;  // 27 MHz / 115200

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } uart_rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic circular-buffer FIFO. Data written in cycle c is at the head in c+1.
// A push is accepted when not full, or when full with a pop in the same cycle. A pop while empty is ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_dat,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_dat,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign pop_dat = mem_q[rd_ptr_q];
    assign count   = cnt_q;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF synchroniser, mid-bit sampling FSM and a receive FIFO.
// A byte reaches the FIFO head one cycle after its stop-bit sample. Bytes arriving at a full FIFO are dropped and flagged.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            io_rxd,
    output logic [UART_DATA_BITS-1:0]       io_rx_data,
    output logic                            io_rx_valid,
    input  logic                            io_rx_ready,
    output logic                            io_framing_error,
    output logic                            io_overrun,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] io_count
);

    localparam int             CW      = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  H_M1    = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]  B_M1    = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]     LAST_BIT = 3'(UART_DATA_BITS - 1);

    uart_rx_state_t            state_q, state_d;
    logic                      sync1_q, sync1_d, sync2_q, sync2_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [2:0]                bit_q, bit_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      fe_q, fe_d, ovr_q, ovr_d;
    logic                      rxd_s, push, pop, fifo_full, fifo_empty;

    assign rxd_s = sync2_q;
    assign pop   = io_rx_valid && io_rx_ready;

    // cnt_q counts from 0 so a full bit period fits in $clog2(CLKS_PER_BIT) bits.
    always_comb begin
        sync1_d = io_rxd;
        sync2_d = sync1_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        push    = 1'b0;
        fe_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rxd_s) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == H_M1) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rxd_s ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == B_M1) begin
                    cnt_d   = '0;
                    shift_d = {rxd_s, shift_q[UART_DATA_BITS-1:1]};
                    if (bit_q == LAST_BIT) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == B_M1) begin
                    cnt_d = '0;
                    if (rxd_s) begin
                        push    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        fe_d    = 1'b1;
                        state_d = WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_IDLE: begin
                if (rxd_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        ovr_d = push && fifo_full && !pop;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            fe_q    <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            fe_q    <= fe_d;
            ovr_q   <= ovr_d;
        end
    end

    sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clock),
        .rst      (reset),
        .push     (push),
        .push_dat (shift_q),
        .pop      (pop),
        .pop_dat  (io_rx_data),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (io_count)
    );

    assign io_rx_valid      = !fifo_empty;
    assign io_framing_error = fe_q;
    assign io_overrun       = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit with a 4-entry FIFO; bytes are scoreboarded on each handshake.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       io_rxd;
    logic [7:0] io_rx_data;
    logic       io_rx_valid;
    logic       io_rx_ready;
    logic       io_framing_error;
    logic       io_overrun;
    logic [2:0] io_count;

    int n_cmp = 0;
    int n_mis = 0;
    int hs_cnt = 0;
    int fe_cnt = 0;
    int ovr_cnt = 0;
    int fe0, ovr0;
    logic [7:0] exp_q[$];

    always #5 clock = ~clock;

    uart_rx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .io_rxd           (io_rxd),
        .io_rx_data       (io_rx_data),
        .io_rx_valid      (io_rx_valid),
        .io_rx_ready      (io_rx_ready),
        .io_framing_error (io_framing_error),
        .io_overrun       (io_overrun),
        .io_count         (io_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic v);
        io_rxd = v;
        repeat (CPB) @(posedge clock);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
    endtask

    task automatic ready_window(input int n);
        io_rx_ready = 1'b1;
        repeat (n) @(posedge clock);
        #1;
        io_rx_ready = 1'b0;
    endtask

    // Scoreboard and pulse counters, sampled mid-cycle.
    always @(negedge clock) begin
        if (io_framing_error) fe_cnt++;
        if (io_overrun) ovr_cnt++;
        if (!reset && io_rx_valid && io_rx_ready) begin
            hs_cnt++;
            if (exp_q.size() == 0) check("sb_unexpected", 32'(io_rx_data), 32'hFFFF_FFFF);
            else check("sb_data", 32'(io_rx_data), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        reset = 1'b1;
        io_rxd = 1'b1;
        io_rx_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("rst_valid", 32'(io_rx_valid), 32'd0);
        check("rst_data",  32'(io_rx_data),  32'd0);
        check("rst_count", 32'(io_count),    32'd0);
        check("rst_fe",    32'(io_framing_error), 32'd0);
        check("rst_ovr",   32'(io_overrun),  32'd0);
        @(posedge clock);
        #1;
        repeat (5) @(posedge clock);
        #1;

        // 1: single byte, ready low, exact arrival cycle
        exp_q.push_back(8'hA5);
        fork
            send_frame(8'hA5, 1'b1);
            begin
                repeat (155) @(negedge clock);
                check("t1_valid_early", 32'(io_rx_valid), 32'd0);
                @(negedge clock);
                check("t1_valid_rise", 32'(io_rx_valid), 32'd1);
                check("t1_data",       32'(io_rx_data),  32'hA5);
                check("t1_count",      32'(io_count),    32'd1);
            end
        join
        check("t1_no_fe",  32'(fe_cnt),  32'd0);
        check("t1_no_ovr", 32'(ovr_cnt), 32'd0);
        ready_window(1);
        check("t1_hs",     32'(hs_cnt),   32'd1);
        check("t1_count0", 32'(io_count), 32'd0);

        // 2: back-to-back frames with ready high
        io_rx_ready = 1'b1;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h3C);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h3C, 1'b1);
        repeat (5) @(posedge clock);
        #1;
        check("t2_hs",    32'(hs_cnt),       32'd4);
        check("t2_sb",    32'(exp_q.size()), 32'd0);
        check("t2_count", 32'(io_count),     32'd0);

        // 3: short low glitch is ignored
        io_rxd = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        io_rxd = 1'b1;
        repeat (20) @(posedge clock);
        #1;
        check("t3_valid", 32'(io_rx_valid), 32'd0);
        check("t3_fe",    32'(fe_cnt),      32'd0);
        check("t3_idle",  32'(dut.state_q), 32'(IDLE));
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        repeat (5) @(posedge clock);
        #1;
        check("t3_hs", 32'(hs_cnt), 32'd5);

        // 4: bad stop bit followed by a long break
        fe0 = fe_cnt;
        fork
            send_frame(8'h81, 1'b0);
            begin
                repeat (155) @(negedge clock);
                check("t4_fe_early", 32'(io_framing_error), 32'd0);
                @(negedge clock);
                check("t4_fe_pulse", 32'(io_framing_error), 32'd1);
                @(negedge clock);
                check("t4_fe_fall",  32'(io_framing_error), 32'd0);
            end
        join
        repeat (40 * CPB) @(posedge clock);
        #1;
        io_rxd = 1'b1;
        repeat (20) @(posedge clock);
        #1;
        check("t4_fe_once", 32'(fe_cnt),   32'(fe0 + 1));
        check("t4_count",   32'(io_count), 32'd0);
        check("t4_hs",      32'(hs_cnt),   32'd5);
        exp_q.push_back(8'h42);
        send_frame(8'h42, 1'b1);
        repeat (5) @(posedge clock);
        #1;
        check("t4_next_hs", 32'(hs_cnt), 32'd6);

        // 5: overrun on the fifth byte into a full FIFO
        io_rx_ready = 1'b0;
        ovr0 = ovr_cnt;
        for (int i = 1; i <= 4; i++) begin
            exp_q.push_back(8'(i));
            send_frame(8'(i), 1'b1);
        end
        fork
            send_frame(8'h05, 1'b1);
            begin
                repeat (155) @(negedge clock);
                check("t5_ovr_early", 32'(io_overrun), 32'd0);
                @(negedge clock);
                check("t5_ovr_pulse", 32'(io_overrun), 32'd1);
            end
        join
        repeat (2) @(posedge clock);
        #1;
        check("t5_count",    32'(io_count),   32'd4);
        check("t5_head",     32'(io_rx_data), 32'h01);
        check("t5_ovr_once", 32'(ovr_cnt),    32'(ovr0 + 1));
        ready_window(8);
        check("t5_hs",     32'(hs_cnt),       32'd10);
        check("t5_sb",     32'(exp_q.size()), 32'd0);
        check("t5_count0", 32'(io_count),     32'd0);

        // 6: pop coinciding with the push into a full FIFO
        ovr0 = ovr_cnt;
        for (int i = 1; i <= 5; i++) exp_q.push_back(8'(i));
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1);
        check("t6_full", 32'(io_count), 32'd4);
        fork
            send_frame(8'h05, 1'b1);
            begin
                repeat (154) @(posedge clock);
                #1;
                io_rx_ready = 1'b1;
                @(posedge clock);
                #1;
                io_rx_ready = 1'b0;
            end
        join
        repeat (2) @(posedge clock);
        #1;
        check("t6_no_ovr", 32'(ovr_cnt),    32'(ovr0));
        check("t6_count",  32'(io_count),   32'd4);
        check("t6_head",   32'(io_rx_data), 32'h02);
        ready_window(8);
        check("t6_hs", 32'(hs_cnt),       32'd15);
        check("t6_sb", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of a frame with a byte buffered
        send_frame(8'h11, 1'b1);
        check("rst2_pre_count", 32'(io_count), 32'd1);
        fork
            send_frame(8'h77, 1'b1);
            begin
                repeat (50) @(posedge clock);
                #1;
                reset = 1'b1;
                @(posedge clock);
                #1;
                reset = 1'b0;
                @(negedge clock);
                check("rst2_valid", 32'(io_rx_valid), 32'd0);
                check("rst2_count", 32'(io_count),    32'd0);
            end
        join
        repeat (20) @(posedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
